uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1, 16x oversampling) feeding a first-word-fall-through byte FIFO.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 80000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          reset,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun,
  output logic                          parity_err,
  input  logic                          err_clr
);

  localparam int unsigned DIV_RAW = CLK_HZ / (BAUD * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CW      = AW + 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [1:0]    sync, sync_ok;
  logic          rxd_s, prev_hi, fall;
  logic [DW-1:0] div_cnt;
  logic          tick, div_clr, tick_clr, shift_en;
  logic [3:0]    tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          brk_q, brk_d, push_q, push_d, set_fe;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, accept;

  assign rxd_s = sync[1];
  // A falling edge only counts once the line has been seen genuinely high,
  // which also ignores the tail of a frame cut short by reset.
  assign fall  = prev_hi & ~rxd_s;
  assign tick  = (div_cnt == DW'(DIV - 1));

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d, set_pe;
`endif

  always_comb begin
    state_d  = state_q;
    div_clr  = 1'b0;
    tick_clr = 1'b0;
    shift_en = 1'b0;
    set_fe   = 1'b0;
    push_d   = 1'b0;
    brk_d    = brk_q;
`ifdef UART_RX_PARITY_EN
    set_pe    = 1'b0;
    par_bad_d = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (fall) begin
          state_d  = START;
          div_clr  = 1'b1;
          tick_clr = 1'b1;
        end
      end
      START: if (tick && tick_cnt == 4'd7) begin
        state_d  = rxd_s ? IDLE : DATA;
        tick_clr = 1'b1;
      end
      DATA: if (tick && tick_cnt == 4'd15) begin
        shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt == 3'd7) state_d = PARITY;
`else
        if (bit_cnt == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick && tick_cnt == 4'd15) begin
        if (rxd_s != ^shreg) begin
          set_pe    = 1'b1;
          par_bad_d = 1'b1;
        end
        state_d = STOP;
      end
`endif
      STOP: begin
        if (brk_q) begin
          if (rxd_s) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (tick && tick_cnt == 4'd15) begin
          if (!rxd_s) begin
            set_fe = 1'b1;
            brk_d  = 1'b1;
          end else begin
`ifdef UART_RX_PARITY_EN
            push_d = ~par_bad_q;
`else
            push_d = 1'b1;
`endif
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sync     <= 2'b11;
      sync_ok  <= '0;
      prev_hi  <= 1'b0;
      div_cnt  <= '0;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      brk_q    <= 1'b0;
      push_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sync    <= {sync[0], rxd};
      sync_ok <= {sync_ok[0], 1'b1};
      prev_hi <= sync_ok[1] & rxd_s;
      brk_q   <= brk_d;
      push_q  <= push_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
      if (div_clr || tick) div_cnt <= '0;
      else                 div_cnt <= div_cnt + DW'(1);
      if (tick_clr)  tick_cnt <= '0;
      else if (tick) tick_cnt <= tick_cnt + 4'd1;
      if (tick_clr)      bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shreg <= {rxd_s, shreg[7:1]};
    end
  end

  // FIFO: a pop frees the slot in the same cycle, so push-while-full succeeds with a pop.
  assign rx_valid = (fifo_count != '0);
  assign full     = (fifo_count == CW'(FIFO_DEPTH));
  assign pop      = rx_valid & rx_ready;
  assign accept   = push_q & (~full | pop);
  assign rx_data  = rx_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge sys_clk) begin
    if (accept) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + AW'(1);
      if (pop)    rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      frame_err <= set_fe | (frame_err & ~err_clr);
      overrun   <= (push_q & full & ~pop) | (overrun & ~err_clr);
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge sys_clk) begin
    if (reset) parity_err <= 1'b0;
    else       parity_err <= set_pe | (parity_err & ~err_clr);
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random frames
// compared against a byte-level queue model of the receiver and FIFO.
module tb_uart_rx_fifo;

  localparam int CLK_HZ = 1600000;
  localparam int BAUD   = 10000;
  localparam int DEPTH  = 4;
  localparam int BIT    = CLK_HZ / BAUD;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b1;
  logic       rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] fifo_count;
  logic       frame_err, overrun, parity_err;

  uart_rx_fifo #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .reset(reset), .rxd(rxd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun),
    .parity_err(parity_err), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  int         errors = 0;
  int         checks = 0;
  int         valid_cycles = 0;
  logic [7:0] rcv_q[$];
  logic [7:0] exp_q[$];
  int         held = 0;
  logic       exp_fe = 1'b0, exp_ovr = 1'b0, exp_pe = 1'b0;

  always @(posedge sys_clk) begin
    if (!reset) begin
      if (rx_valid) valid_cycles++;
      if (rx_valid && rx_ready) rcv_q.push_back(rx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BIT) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
    drive_bit(stop_bit);
    rxd = 1'b1;
  endtask

  // Reference: a frame with a good stop bit (and good parity) delivers its byte,
  // unless the consumer is stalled and DEPTH bytes are already waiting.
  task automatic xfer(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    logic par_ok;
    par_ok = 1'b1;
`ifdef UART_RX_PARITY_EN
    par_ok = ~par_flip;
    if (!par_ok) exp_pe = 1'b1;
`endif
    send_frame(b, stop_bit, par_flip);
    if (!stop_bit) exp_fe = 1'b1;
    else if (par_ok) begin
      if (rx_ready) exp_q.push_back(b);
      else if (held < DEPTH) begin
        exp_q.push_back(b);
        held++;
      end else exp_ovr = 1'b1;
    end
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_fe));
    check({tag, ".overrun"}, 32'(overrun), 32'(exp_ovr));
    check({tag, ".parity_err"}, 32'(parity_err), 32'(exp_pe));
    check({tag, ".count"}, 32'(fifo_count), rx_ready ? 32'd0 : 32'(held));
  endtask

  task automatic compare_rx(input string tag);
    int n;
    check({tag, ".nbytes"}, 32'(rcv_q.size()), 32'(exp_q.size()));
    n = (rcv_q.size() < exp_q.size()) ? rcv_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, ".byte"}, 32'(rcv_q[i]), 32'(exp_q[i]));
    rcv_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    @(negedge sys_clk);
    exp_fe = 1'b0;
    exp_ovr = 1'b0;
    exp_pe = 1'b0;
  endtask

  initial begin
    repeat (4) @(negedge sys_clk);
    check("rst.valid", 32'(rx_valid), 32'd0);
    check("rst.data", 32'(rx_data), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge sys_clk);
    check_state("rst");

    // single byte, consumer always ready
    rx_ready = 1'b1;
    valid_cycles = 0;
    xfer(8'hA5, 1'b1, 1'b0);
    check("a5.valid_cycles", 32'(valid_cycles), 32'd1);
    check_state("a5");
    compare_rx("a5");

    // five bytes with a stalled consumer
    rx_ready = 1'b0;
    held = 0;
    for (int i = 1; i <= 5; i++) xfer(8'(i), 1'b1, 1'b0);
    check_state("ovr");
    rx_ready = 1'b1;
    repeat (6) @(negedge sys_clk);
    held = 0;
    check("ovr.valid_after", 32'(rx_valid), 32'd0);
    compare_rx("ovr");
    pulse_clr();
    check_state("ovr_clr");

    // stop bit forced low
    xfer(8'h3C, 1'b0, 1'b0);
    check_state("fe");
    pulse_clr();
    check_state("fe_clr");
    compare_rx("fe");

    // 3-tick glitch, then a real frame proves the receiver is idle again
    rxd = 1'b0;
    repeat (30) @(negedge sys_clk);
    rxd = 1'b1;
    repeat (300) @(negedge sys_clk);
    check("glitch.nbytes", 32'(rcv_q.size()), 32'd0);
    check_state("glitch");
    xfer(8'h5A, 1'b1, 1'b0);
    compare_rx("post_glitch");

    // reset in the middle of data bit 4 of 0xFF
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        repeat (BIT * 5 + BIT / 2) @(negedge sys_clk);
        reset = 1'b1;
        @(negedge sys_clk);
        reset = 1'b0;
      end
    join
    repeat (4) @(negedge sys_clk);
    check_state("midrst");
    xfer(8'h12, 1'b1, 1'b0);
    compare_rx("midrst");

`ifdef UART_RX_PARITY_EN
    xfer(8'h07, 1'b1, 1'b1);
    check_state("par_bad");
    pulse_clr();
    xfer(8'h07, 1'b1, 1'b0);
    check_state("par_good");
    compare_rx("par");
`endif

    // random frames with occasional bad stop/parity and flag clears
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      logic       sb, pf;
      b  = 8'($urandom);
      sb = ($urandom_range(0, 3) != 0);
      pf = ($urandom_range(0, 3) == 0);
      xfer(b, sb, pf);
      check_state("rand");
      if ($urandom_range(0, 1) == 1) pulse_clr();
      repeat ($urandom_range(20, 200)) @(negedge sys_clk);
    end
    compare_rx("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
